// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer for a 1-bit combinational ALU slice: streams operands LSB-first,
// chains carry, reassembles the result. Optional zero flag: BIT_SERIAL_ALU_ZERO_FLAG_EN.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       opsel_in,
  input  logic             cin_init,
  output logic             op1,
  output logic             op2,
  output logic             cin,
  output logic [2:0]       opsel,
  input  logic             slice_result,
  input  logic             slice_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_final
`ifdef BIT_SERIAL_ALU_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic             accept;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, res_sr_reg, result_reg;
  logic [2:0]       opsel_reg;
  logic             carry_reg, cout_final_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             last_bit;
  logic [WIDTH-1:0] res_shifted;

  assign last_bit    = (cnt_reg == CNT_W'(WIDTH - 1));
  assign res_shifted = {slice_result, res_sr_reg[WIDTH-1:1]};

  // Slice inputs come straight from registers so start never reaches them combinationally.
  assign op1        = a_sr_reg[0];
  assign op2        = b_sr_reg[0];
  assign cin        = carry_reg;
  assign opsel      = opsel_reg;
  assign result     = result_reg;
  assign cout_final = cout_final_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_reg       <= '0;
      b_sr_reg       <= '0;
      res_sr_reg     <= '0;
      result_reg     <= '0;
      opsel_reg      <= '0;
      cnt_reg        <= '0;
      carry_reg      <= 1'b0;
      cout_final_reg <= 1'b0;
`ifdef BIT_SERIAL_ALU_ZERO_FLAG_EN
      zero           <= 1'b0;
`endif
    end else if (accept) begin
      a_sr_reg   <= a_in;
      b_sr_reg   <= b_in;
      opsel_reg  <= opsel_in;
      carry_reg  <= cin_init;
      cnt_reg    <= '0;
      res_sr_reg <= '0;
    end else if (state_reg == ST_SHIFT) begin
      a_sr_reg   <= a_sr_reg >> 1;
      b_sr_reg   <= b_sr_reg >> 1;
      res_sr_reg <= res_shifted;
      carry_reg  <= slice_cout;
      if (last_bit) begin
        // Final bit: publish the word; it stays put until the next accepted op completes.
        result_reg     <= res_shifted;
        cout_final_reg <= slice_cout;
`ifdef BIT_SERIAL_ALU_ZERO_FLAG_EN
        zero           <= (res_shifted == '0);
`endif
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule
